// File: rtl/vx_tex_sched.sv
// vx_tex_sched: round-robin scheduler in front of the shared texture address
// pipeline. Arbitrates NUM_INPUTS requesters, tags each grant with its source
// index, bounds in-flight work with a credit counter and steers completed
// responses back to their owner.
// Optional: define TEX_SCHED_PERF_EN to add issue/stall performance counters.
module vx_tex_sched #(
  parameter int CORE_ID     = 0,
  parameter int NUM_INPUTS  = 4,
  parameter int REQ_DATAW   = 128,
  parameter int RSP_DATAW   = 128,
  parameter int MAX_PENDING = 8,
  localparam int TAG_BITS   = $clog2(NUM_INPUTS),
  localparam int CNT_BITS   = $clog2(MAX_PENDING + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_INPUTS-1:0]                 req_valid,
  input  logic [NUM_INPUTS-1:0][REQ_DATAW-1:0]  req_data,
  output logic [NUM_INPUTS-1:0]                 req_ready,
  output logic                                  sched_valid,
  output logic [REQ_DATAW-1:0]                  sched_data,
  output logic [TAG_BITS-1:0]                   sched_tag,
  input  logic                                  sched_ready,
  input  logic                                  done_valid,
  input  logic [TAG_BITS-1:0]                   done_tag,
  input  logic [RSP_DATAW-1:0]                  done_data,
  output logic                                  done_ready,
  output logic [NUM_INPUTS-1:0]                 rsp_valid,
  output logic [RSP_DATAW-1:0]                  rsp_data,
  input  logic [NUM_INPUTS-1:0]                 rsp_ready,
  output logic [CNT_BITS-1:0]                   pending
`ifdef TEX_SCHED_PERF_EN
  ,
  output logic [31:0]                           perf_issue_cnt,
  output logic [31:0]                           perf_stall_cnt
`endif
);

  logic                 vld_p1;
  logic [REQ_DATAW-1:0] data_p1;
  logic [TAG_BITS-1:0]  tag_p1;
  logic [TAG_BITS-1:0]  rr_ptr;
  logic [CNT_BITS-1:0]  pend_cnt;

  logic                 can_issue;
  logic                 grant_found;
  logic [TAG_BITS-1:0]  grant_idx;
  logic                 accept;
  logic                 retire;

  // ---- stage p0: arbitration over requesters ----

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr) + k) % NUM_INPUTS]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_BITS'((int'(rr_ptr) + k) % NUM_INPUTS);
      end
    end
  end

  assign can_issue = (pend_cnt < CNT_BITS'(MAX_PENDING)) & (~vld_p1 | sched_ready);
  assign accept    = can_issue & grant_found;
  assign req_ready = accept ? (NUM_INPUTS'(1) << grant_idx) : '0;
  assign retire    = done_valid & done_ready;

  // ---- stage p1: output register toward the address stage ----

  // Valid bit and round-robin pointer: reset-controlled state.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      rr_ptr <= '0;
    end else begin
      if (~vld_p1 | sched_ready)
        vld_p1 <= accept;
      if (accept)
        rr_ptr <= (grant_idx == TAG_BITS'(NUM_INPUTS - 1)) ? '0 : grant_idx + TAG_BITS'(1);
    end
  end

  // Payload and tag load on accept only; qualified by vld_p1, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1 <= req_data[grant_idx];
      tag_p1  <= grant_idx;
    end
  end

  assign sched_valid = vld_p1;
  assign sched_data  = data_p1;
  assign sched_tag   = tag_p1;

  // Credit counter: +1 per accept, -1 per retire, saturating at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt <= '0;
    end else begin
      if (accept && !retire)
        pend_cnt <= pend_cnt + CNT_BITS'(1);
      else if (!accept && retire && pend_cnt != '0)
        pend_cnt <= pend_cnt - CNT_BITS'(1);
`ifndef SYNTHESIS
      assert (!(retire && pend_cnt == '0))
        else $error("vx_tex_sched[%0d]: retire with no request in flight", CORE_ID);
`endif
    end
  end

  assign pending = pend_cnt;

  // Response routing back to the owning requester (zero latency, unbuffered).
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      rsp_valid[i] = done_valid & (done_tag == TAG_BITS'(i));
  end

  assign rsp_data   = done_data;
  assign done_ready = rsp_ready[done_tag];

`ifdef TEX_SCHED_PERF_EN
  // Issue and stall event counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (|req_valid && !accept)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_tex_sched.sv
// Testbench for vx_tex_sched: reference model plus scoreboard queue of
// expected {tag, payload} entries for the output register.
module tb_vx_tex_sched;
  localparam int NI   = 4;
  localparam int RQW  = 32;
  localparam int RSW  = 32;
  localparam int MAXP = 8;
  localparam int TB   = 2;
  localparam int CB   = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NI-1:0]            rv;
  logic [NI-1:0][RQW-1:0]   req_data;
  logic [NI-1:0]            req_ready;
  logic                     sched_valid;
  logic [RQW-1:0]           sched_data;
  logic [TB-1:0]            sched_tag;
  logic                     srdy;
  logic                     dv;
  logic [TB-1:0]            dtag;
  logic [RSW-1:0]           ddata;
  logic                     done_ready;
  logic [NI-1:0]            rsp_valid;
  logic [RSW-1:0]           rsp_data;
  logic [NI-1:0]            rrdy;
  logic [CB-1:0]            pending;
`ifdef TEX_SCHED_PERF_EN
  logic [31:0]              perf_issue_cnt;
  logic [31:0]              perf_stall_cnt;
`endif

  vx_tex_sched #(
    .CORE_ID(0), .NUM_INPUTS(NI), .REQ_DATAW(RQW), .RSP_DATAW(RSW), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .reset(rst),
    .req_valid(rv), .req_data(req_data), .req_ready(req_ready),
    .sched_valid(sched_valid), .sched_data(sched_data), .sched_tag(sched_tag),
    .sched_ready(srdy),
    .done_valid(dv), .done_tag(dtag), .done_data(ddata), .done_ready(done_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rrdy),
    .pending(pending)
`ifdef TEX_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TB-1:0]  tag;
    logic [RQW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   seq   = 0;
  int   m_ptr = 0;
  int   m_pend = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Run n cycles with the current control inputs, checking every output
  // against the model at the falling edge and advancing the model at the
  // rising edge.
  task automatic cyc(input int n);
    bit            can, found, acc, ret, pop;
    int            g;
    logic [NI-1:0] exp_rdy, exp_rv;
    for (int c = 0; c < n; c++) begin
      seq++;
      for (int i = 0; i < NI; i++) req_data[i] = {8'(i + 8'hA0), 24'(seq)};
      ddata = 32'(seq * 7 + 32'h5000);
      @(negedge clk);
      can   = (m_pend < MAXP) && (sb.size() == 0 || srdy);
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < NI; k++) begin
        if (!found && rv[(m_ptr + k) % NI]) begin
          found = 1'b1;
          g     = (m_ptr + k) % NI;
        end
      end
      acc     = can && found;
      exp_rdy = acc ? NI'(1 << g) : '0;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("sched_valid", 64'(sched_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("sched_tag", 64'(sched_tag), 64'(sb[0].tag));
        check("sched_data", 64'(sched_data), 64'(sb[0].data));
      end
      check("pending", 64'(pending), 64'(m_pend));
      exp_rv = dv ? NI'(1 << dtag) : '0;
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("done_ready", 64'(done_ready), 64'(rrdy[dtag]));
      if (dv) check("rsp_data", 64'(rsp_data), 64'(ddata));
      ret = dv && rrdy[dtag];
      pop = (sb.size() != 0) && srdy;
      @(posedge clk);
      if (rst) begin
        sb.delete();
        m_ptr  = 0;
        m_pend = 0;
      end else begin
        if (pop) void'(sb.pop_front());
        if (acc) begin
          sb.push_back('{tag: TB'(g), data: req_data[g]});
          m_ptr = (g + 1) % NI;
        end
        if (acc && !ret) m_pend++;
        else if (!acc && ret && m_pend > 0) m_pend--;
      end
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; rv = '0; srdy = 1'b0; dv = 1'b0; dtag = '0; rrdy = '0;
    req_data = '0; ddata = '0;
    cyc(2);
    rst = 1'b0;
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_sched_valid", 64'(sched_valid), 64'd0);

    // Fill all credits: tags 0,1,2,3,0,1,2,3 then stall on full.
    rv = 4'b1111; srdy = 1'b1;
    cyc(10);
    check("full_pending", 64'(pending), 64'd8);
    check("full_req_ready", 64'(req_ready), 64'd0);

    // Single retire from the full state re-enables one grant next cycle.
    dv = 1'b1; dtag = 2'd2; rrdy = 4'b0100;
    cyc(1);
    check("retire_pending", 64'(pending), 64'd7);
    dv = 1'b0;
    cyc(1);
    check("regrant_pending", 64'(pending), 64'd8);

    // Drain three credits with no new requests.
    rv = '0; dv = 1'b1; dtag = 2'd1; rrdy = 4'b1111;
    cyc(3);
    dv = 1'b0;
    check("drain_pending", 64'(pending), 64'd5);

    // Backpressure: one load, then five held cycles, then bubble-free release.
    rv = 4'b1111; srdy = 1'b0;
    cyc(6);
    srdy = 1'b1;
    cyc(1);
    check("bp_pending", 64'(pending), 64'd7);

    // Mid-stream reset with pending=6 and a held request.
    rv = '0; srdy = 1'b0; dv = 1'b1; dtag = 2'd0;
    cyc(1);
    dv = 1'b0;
    check("prerst_pending", 64'(pending), 64'd6);
    check("prerst_valid", 64'(sched_valid), 64'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_pending", 64'(pending), 64'd0);
    check("midrst_valid", 64'(sched_valid), 64'd0);

    // Pointer to 2, then req_valid=1010 grants 3,1,3.
    rv = 4'b0010; srdy = 1'b1;
    cyc(1);
    check("rr_first", 64'(sched_tag), 64'd1);
    rv = 4'b1010;
    cyc(1);
    check("rr_grant3a", 64'(sched_tag), 64'd3);
    cyc(1);
    check("rr_grant1", 64'(sched_tag), 64'd1);
    cyc(1);
    check("rr_grant3b", 64'(sched_tag), 64'd3);
    cyc(1);
    check("pre_sim_pending", 64'(pending), 64'd5);
    dv = 1'b1; dtag = 2'd3; rrdy = 4'b1000;
    cyc(1);
    dv = 1'b0;
    check("sim_acc_ret_pending", 64'(pending), 64'd5);

    // Random traffic against the model.
    for (int r = 0; r < 400; r++) begin
      rv   = NI'($urandom_range(0, 15));
      srdy = ($urandom_range(0, 3) != 0);
      rrdy = NI'($urandom_range(0, 15));
      dtag = TB'($urandom_range(0, 3));
      dv   = (m_pend > 0) && ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    dv = 1'b0;

`ifdef TEX_SCHED_PERF_EN
    // 10 accepts and 3 blocked cycles from a fresh reset.
    rv = '0; rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    rv = 4'b1111; srdy = 1'b1;
    cyc(11);
    rv = '0; dv = 1'b1; rrdy = 4'b1111; dtag = 2'd0;
    cyc(2);
    dv = 1'b0; rv = 4'b1111;
    cyc(2);
    rv = '0;
    check("perf_issue", 64'(perf_issue_cnt), 64'd10);
    check("perf_stall", 64'(perf_stall_cnt), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
